// File: rtl/loop_led_gen_pkg.sv
// Shared constants and the initial-pattern helper for the LED pattern generator.
// init_pattern works on a MAX_W-bit vector; callers slice it down to their WIDTH (WIDTH <= MAX_W).
package loop_led_pkg;

    localparam logic [1:0] MODE_FILL   = 2'd0;
    localparam logic [1:0] MODE_RUN    = 2'd1;
    localparam logic [1:0] MODE_BOUNCE = 2'd2;
    localparam logic [1:0] MODE_BLINK  = 2'd3;

    localparam logic DIR_LEFT  = 1'b1;
    localparam logic DIR_RIGHT = 1'b0;

    localparam int MAX_W = 64;

    function automatic logic [MAX_W-1:0] init_pattern(input logic [1:0]   mode,
                                                      input logic         dir,
                                                      input int unsigned  width);
        logic [MAX_W-1:0] pat;
        pat = '0;
        if (mode == MODE_RUN || mode == MODE_BOUNCE) begin
            if (dir == DIR_LEFT) pat = MAX_W'(1);
            else                 pat = MAX_W'(1) << (width - 1);
        end
        return pat;
    endfunction

endpackage

// File: rtl/loop_led_gen_prescaler.sv
// Step prescaler: ticks once every BASE_DIV>>speed enabled clocks (minimum 1).
module led_prescaler #(
    parameter int BASE_DIV = 50000000,
    parameter int CNT_W    = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] speed,
    output logic       tick
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] limit;

    // >= rather than == so a speed increase with cnt_q already past the new limit ticks at once
    always_comb begin
        limit = CNT_W'(BASE_DIV) >> speed;
        if (limit == '0) limit = CNT_W'(1);
        tick  = en && (cnt_q >= limit - CNT_W'(1));
        cnt_d = cnt_q;
        if (tick)    cnt_d = '0;
        else if (en) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/loop_led_gen.sv
// LED pattern generator: fill / run / bounce / blink patterns stepped by the prescaler.
// A mode change (or a dir change in FILL) reloads the pattern and restarts the prescaler.
module loop_led_gen
    import loop_led_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int BASE_DIV = 50000000,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             dir,
    input  logic [1:0]       speed,
    output logic [WIDTH-1:0] led_out,
    output logic             step_pulse
);

    logic [WIDTH-1:0] led_q, led_d;
    logic [1:0]       mode_q, mode_d;
    logic             dir_q, dir_d;
    logic             bnc_q, bnc_d;
    logic             pulse_q, pulse_d;

    logic             reload;
    logic             tick;
    logic             dir_sel;
    logic             onehot;
    logic [MAX_W-1:0] init_wide;
    logic [WIDTH-1:0] led_init;

    assign reload = (mode != mode_q) || (mode_q == MODE_FILL && dir != dir_q);

    led_prescaler #(
        .BASE_DIV (BASE_DIV),
        .CNT_W    (CNT_W)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst || reload),
        .en    (en),
        .speed (speed),
        .tick  (tick)
    );

    // RUN recovers toward the live dir; BOUNCE recovers toward the dir latched at reload
    assign dir_sel   = (!reload && mode_q == MODE_BOUNCE) ? dir_q : dir;
    assign init_wide = init_pattern(reload ? mode : mode_q, dir_sel, WIDTH);
    assign led_init  = init_wide[WIDTH-1:0];
    assign onehot    = (led_q != '0) && ((led_q & (led_q - WIDTH'(1))) == '0);

    always_comb begin
        led_d   = led_q;
        mode_d  = mode_q;
        dir_d   = dir_q;
        bnc_d   = bnc_q;
        pulse_d = 1'b0;
        if (reload) begin
            mode_d = mode;
            dir_d  = dir;
            bnc_d  = dir;
            led_d  = led_init;
        end else if (tick) begin
            pulse_d = 1'b1;
            case (mode_q)
                MODE_FILL: begin
                    if (&led_q)                led_d = '0;
                    else if (dir_q == DIR_LEFT) led_d = {led_q[WIDTH-2:0], 1'b1};
                    else                       led_d = {1'b1, led_q[WIDTH-1:1]};
                end
                MODE_RUN: begin
                    if (!onehot)              led_d = led_init;
                    else if (dir == DIR_LEFT) led_d = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
                    else                      led_d = {led_q[0], led_q[WIDTH-1:1]};
                end
                MODE_BOUNCE: begin
                    if (!onehot) begin
                        led_d = led_init;
                        bnc_d = dir_q;
                    end else if (bnc_q == DIR_LEFT) begin
                        if (led_q[WIDTH-1]) begin
                            bnc_d = DIR_RIGHT;
                            led_d = led_q >> 1;
                        end else begin
                            led_d = led_q << 1;
                        end
                    end else begin
                        if (led_q[0]) begin
                            bnc_d = DIR_LEFT;
                            led_d = led_q << 1;
                        end else begin
                            led_d = led_q >> 1;
                        end
                    end
                end
                default: led_d = ~led_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led_q   <= '0;
            mode_q  <= MODE_FILL;
            dir_q   <= DIR_LEFT;
            bnc_q   <= DIR_LEFT;
            pulse_q <= 1'b0;
        end else begin
            led_q   <= led_d;
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            bnc_q   <= bnc_d;
            pulse_q <= pulse_d;
        end
    end

    assign led_out    = led_q;
    assign step_pulse = pulse_q;

endmodule

// File: tb/tb_loop_led_gen.sv
// Bench for loop_led_gen (WIDTH=8, BASE_DIV=8): directed plan plus random segments,
// expected steps queued by an abstract pattern model and popped by a step_pulse monitor.
module tb_loop_led_gen;

    localparam int W  = 8;
    localparam int BD = 8;

    logic       clk = 1'b0;
    logic       rst, en, dir;
    logic [1:0] mode, speed;
    logic [7:0] led_out;
    logic       step_pulse;

    loop_led_gen #(.WIDTH(W), .BASE_DIV(BD), .CNT_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .mode       (mode),
        .dir        (dir),
        .speed      (speed),
        .led_out    (led_out),
        .step_pulse (step_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] led;
    } step_t;

    step_t sb[$];
    int    cyc    = 0;
    int    n_chk  = 0;
    int    n_fail = 0;

    // abstract model: fill count, lit position, bounce heading, blink phase, step counter
    int m_mode, m_dir_r, m_q, fill_n, pos;
    bit bleft, blink_on, m_stepped;

    function automatic logic [7:0] render();
        int v;
        case (m_mode)
            0:       v = m_dir_r ? ((1 << fill_n) - 1) : ((255 << (8 - fill_n)) & 255);
            1, 2:    v = 1 << pos;
            default: v = blink_on ? 255 : 0;
        endcase
        return v[7:0];
    endfunction

    task automatic advance();
        case (m_mode)
            0: fill_n = (fill_n + 1) % 9;
            1: pos = dir ? (pos + 1) % 8 : (pos + 7) % 8;
            2: begin
                if (bleft) begin
                    if (pos == 7) begin bleft = 0; pos = 6; end
                    else pos++;
                end else begin
                    if (pos == 0) begin bleft = 1; pos = 1; end
                    else pos--;
                end
            end
            default: blink_on = !blink_on;
        endcase
    endtask

    task automatic model_eval();
        int    limit;
        step_t e;
        m_stepped = 0;
        if (rst) begin
            m_mode = 0; m_dir_r = 1; m_q = 0; fill_n = 0;
        end else if (int'(mode) != m_mode || (m_mode == 0 && int'(dir) != m_dir_r)) begin
            m_mode = mode; m_dir_r = dir; m_q = 0;
            fill_n = 0; pos = dir ? 0 : 7; bleft = dir; blink_on = 0;
        end else if (en) begin
            limit = BD >> speed;
            if (limit < 1) limit = 1;
            if (m_q >= limit - 1) begin
                m_q = 0;
                advance();
                m_stepped = 1;
                e.cyc = cyc + 1;
                e.led = render();
                sb.push_back(e);
            end else begin
                m_q++;
            end
        end
    endtask

    task automatic cycle();
        model_eval();
        @(posedge clk);
        #2;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic check_now(input string name, input logic [7:0] el, input logic ep);
        n_chk++;
        if (led_out !== el || step_pulse !== ep) begin
            n_fail++;
            $display("FAIL %s: led_out=%h step_pulse=%b, expected led_out=%h step_pulse=%b",
                     name, led_out, step_pulse, el, ep);
        end
    endtask

    task automatic run_until_led(input string name, input logic [7:0] target, input int budget);
        bit hit = 0;
        for (int k = 0; k < budget && !hit; k++) begin
            cycle();
            if (render() == target) hit = 1;
        end
        if (!hit) begin
            n_chk++; n_fail++;
            $display("FAIL %s: led_out=%h never reached %h within %0d cycles", name, led_out, target, budget);
        end
    endtask

    task automatic run_until_step(input string name, input int budget);
        bit hit = 0;
        for (int k = 0; k < budget && !hit; k++) begin
            cycle();
            if (m_stepped) hit = 1;
        end
        if (!hit) begin
            n_chk++; n_fail++;
            $display("FAIL %s: no step within %0d cycles", name, budget);
        end
    endtask

    task automatic run_until_q(input int target, input int budget);
        bit hit = 0;
        for (int k = 0; k < budget && !hit; k++) begin
            cycle();
            if (m_q == target) hit = 1;
        end
        if (!hit) begin
            n_chk++; n_fail++;
            $display("FAIL wait_q: count never reached %0d within %0d cycles", target, budget);
        end
    endtask

    // monitor: every step_pulse must match the head of the queue; overdue entries are misses
    always @(posedge clk) begin
        step_t e;
        cyc++;
        #1;
        if (step_pulse === 1'b1) begin
            n_chk++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL step_unexpected: cycle %0d led_out=%h, expected no step", cyc, led_out);
            end else begin
                e = sb.pop_front();
                if (e.cyc != cyc || e.led !== led_out) begin
                    n_fail++;
                    $display("FAIL step: cycle %0d led_out=%h, expected cycle %0d led_out=%h",
                             cyc, led_out, e.cyc, e.led);
                end
            end
        end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            n_chk++; n_fail++;
            e = sb.pop_front();
            $display("FAIL step_missed: cycle %0d step_pulse=%b, expected step to %h", cyc, step_pulse, e.led);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        rst = 1; en = 0; mode = 2'd0; dir = 1; speed = 2'd0;
        run(2);
        check_now("reset", 8'h00, 1'b0);
        rst = 0;

        // 1: fill left, one step every 8 clocks, wraps after 9 steps
        en = 1;
        run(8);
        check_now("fill_first", 8'h01, 1'b1);
        run(56);
        check_now("fill_full", 8'hFF, 1'b1);
        run(8);
        check_now("fill_wrap", 8'h00, 1'b1);
        run(20);

        // 2: run left, then dir flip at 0x10
        mode = 2'd1; dir = 1;
        cycle();
        check_now("run_reload", 8'h01, 1'b0);
        run_until_led("run_reach10", 8'h10, 60);
        dir = 0;
        run_until_step("run_dirflip", 10);
        check_now("run_dir_change", 8'h08, 1'b1);
        run(40);

        // 3: bounce, dir ignored after reload
        mode = 2'd2; dir = 1;
        cycle();
        check_now("bounce_reload", 8'h01, 1'b0);
        run_until_led("bounce_reach80", 8'h80, 80);
        dir = 0;
        run_until_step("bounce_turnstep", 10);
        check_now("bounce_turn", 8'h40, 1'b1);
        run(60);
        dir = 1;
        run(60);

        // 4: speed changes
        speed = 2'd3;
        cycle();
        check_now("speed3_step", render(), 1'b1);
        run(10);
        speed = 2'd0;
        run_until_q(5, 20);
        speed = 2'd2;
        cycle();
        check_now("speed_jump", render(), 1'b1);
        run(1);
        check_now("speed2_idle", render(), 1'b0);
        run(1);
        check_now("speed2_step", render(), 1'b1);
        run(10);

        // 5: freeze, mode change while frozen, resume in blink
        speed = 2'd0; mode = 2'd1; dir = 1;
        run(21);
        en = 0;
        run(20);
        check_now("hold", render(), 1'b0);
        mode = 2'd3;
        cycle();
        check_now("blink_reload", 8'h00, 1'b0);
        en = 1;
        run(7);
        check_now("blink_wait", 8'h00, 1'b0);
        run(1);
        check_now("blink_on", 8'hFF, 1'b1);
        run(8);
        check_now("blink_off", 8'h00, 1'b1);

        // 6: reset mid-run, then reload from the still-applied mode
        mode = 2'd1; dir = 1;
        run_until_led("run_reach20", 8'h20, 60);
        rst = 1;
        cycle();
        check_now("rst_mid", 8'h00, 1'b0);
        rst = 0;
        cycle();
        check_now("rst_reload", 8'h01, 1'b0);
        run(20);

        // random segments
        for (int s = 0; s < 40; s++) begin
            if ($urandom_range(0, 9) == 0) begin
                rst = 1;
                cycle();
                check_now("rand_reset", 8'h00, 1'b0);
                rst = 0;
            end
            mode  = 2'($urandom_range(0, 3));
            dir   = 1'($urandom_range(0, 1));
            speed = 2'($urandom_range(0, 3));
            en    = ($urandom_range(0, 4) != 0);
            len   = $urandom_range(5, 60);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 15) == 0) dir = ~dir;
                cycle();
            end
        end

        en = 0;
        run(4);
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d steps still pending, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/loop_led_gen.md
Name: loop_led_gen

Overview:
Parametrised LED pattern generator that drives a WIDTH-bit LED bank for the board demo designs. It combines a step prescaler with runtime-selectable speed and a pattern engine with four modes (fill, run, bounce, blink) and a direction control. It sits directly between the board clock and the LED pins, with one step every BASE_DIV>>speed clocks.

Parameters:
WIDTH, 8, number of LEDs; legal range is WIDTH >= 2.
BASE_DIV, 50000000, clocks per step at speed=0; legal range is BASE_DIV >= 8.
CNT_W, 32, prescaler counter width; must satisfy 2^CNT_W > BASE_DIV.

Ports:
clk  input  1  system clock (one clock domain)
rst  input  1  synchronous, active-high reset
en  input  1  1 = run; 0 = freeze the prescaler and the pattern
mode  input  2  0 FILL, 1 RUN, 2 BOUNCE, 3 BLINK
dir  input  1  1 = toward the MSB (left), 0 = toward the LSB
speed  input  2  step divider is BASE_DIV >> speed
led_out  output  WIDTH  LED drive, registered
step_pulse  output  1  one-cycle strobe on every pattern step

Behaviour:
- Reset: rst is sampled on the clk edge. On reset: led_out=0, step_pulse=0, q=0, mode_r=FILL, dir_r=1, bnc_dir=left.
- Prescaler: limit = BASE_DIV >> speed, evaluated every cycle, with a minimum value of 1.
  - tick is asserted when en=1 and q >= limit-1; q then returns to 0. Otherwise, when en=1, q increments.
  - The >= comparison is required so that a speed increase while q is above the new limit ticks on the next cycle.
  - When en=0, q holds and no tick is produced.
- Latency: the first step comes BASE_DIV>>speed enabled cycles after a reload or reset. led_out and step_pulse update on the same edge.
- Reload: if mode != mode_r, or if (mode_r==FILL and dir != dir_r):
  - mode_r and dir_r are latched, q=0, and led_out is set to the initial pattern.
  - No step_pulse is produced. Reload happens even when en=0.
- Initial patterns:
  - FILL: 0.
  - RUN and BOUNCE: 1 at bit0 if dir=1, otherwise at bit WIDTH-1. For BOUNCE, bnc_dir is set to match.
  - BLINK: 0.
- Step rules (applied on tick):
  - FILL, dir=1: {led[W-2:0],1}. dir=0: {1,led[W-1:1]}. When led_out is all ones, the next value is 0, giving a cycle of WIDTH+1 states.
  - RUN: rotate left if dir=1, rotate right if dir=0. A dir change takes effect at the next step from the current position, with no reload.
  - BOUNCE: shift in the direction of bnc_dir. At bit WIDTH-1 with bnc_dir=left, set bnc_dir=right and move to bit WIDTH-2; the mirror case applies at bit0. dir is ignored after reload.
  - BLINK: led_out = ~led_out; the sequence is all ones, then all zeros.
- Robustness: if RUN or BOUNCE finds led_out is not one-hot at a tick, it loads the initial pattern instead of stepping (step_pulse is still asserted).
- Priority, highest first: rst > reload > en=0 hold > tick step > idle.
- step_pulse is high only in the cycle after a tick-driven update. It is never high during reset or reload.

Decomposition:
- Package loop_led_pkg holds:
  - the MODE_FILL / MODE_RUN / MODE_BOUNCE / MODE_BLINK 2-bit constants;
  - DIR_LEFT and DIR_RIGHT;
  - a function returning the initial pattern for a given mode and dir.
- Sub-module led_prescaler (params BASE_DIV, CNT_W; ports clk, rst, en, speed, tick) holds the q counter and the limit compare.
- loop_led_gen instantiates led_prescaler and contains the pattern register, mode_r, dir_r and bnc_dir.

Test Plan:
All scenarios use WIDTH=8 and BASE_DIV=8.
1. Reset, then mode=0, dir=1, en=1, speed=0 -> led_out steps 00,01,03,07,...,FF,00 every 8 clocks. step_pulse is high on each step; the pattern wraps after 9 steps.
2. mode=1, dir=1 -> 01,02,04,...,80,01. Set dir=0 while at 10 -> the next step is 08 with no reload and the q count is unaffected.
3. mode=2, dir=1 -> 01,02,...,80,40,20,...,01,02. Toggling dir mid-run has no effect.
4. speed=3 (limit 1) -> a step every clock. Then, with speed=0 and q=5, set speed=2 (limit 2) -> tick on the next cycle, then a step every 2 clocks.
5. Hold en=0 for 20 cycles -> led_out and q are frozen and step_pulse stays 0. Change mode 1->3 while en=0 -> led_out=00 on the next edge, q=0, no step_pulse. Set en=1 -> FF after 8 clocks.
6. Assert rst for one cycle mid-RUN at led_out=20 -> led_out=00 and step_pulse=0 on the next edge. With mode=1 still applied -> reload to 01 the following cycle.
